uart_tx_axis: RTL and testbench
===============================

// Module: uart_tx_axis
// PURPOSE
//   UART transmitter with an AXI-Stream slave input. It is the transmit-side partner of the
//   team's AXI-Stream UART receiver and uses the same prescale convention:
//   1 bit period = prescale*8 clk cycles.
//   Serialises one word per accepted beat: start bit, DATA_WIDTH data bits LSB-first,
//   optional parity bit, then 1 or 2 stop bits.
// PARAMETERS
//   DATA_WIDTH  8  data bits per frame (5..9 legal)
//   PARITY      0  0 = none, 1 = odd, 2 = even; parity is computed over the captured word
//   STOP_BITS   1  number of stop bits, 1 or 2
// PORTS
//   clk            in   1           single clock; all logic on posedge
//   rst            in   1           synchronous, active-high reset
//   s_axis_tdata   in   DATA_WIDTH  word to transmit
//   s_axis_tvalid  in   1           source has a word
//   s_axis_tready  out  1           registered; high only when idle and able to accept
//   txd            out  1           serial line; idle high
//   busy           out  1           high while a frame is being shifted out
//   prescale       in   16          bit period in units of 8 clk cycles
// BEHAVIOUR
//   Reset (edge with rst=1): txd=1, busy=0, s_axis_tready=0, state=IDLE, counters=0.
//     - First edge with rst=0 sets s_axis_tready=1.
//     - Reset mid-frame abandons the frame; txd returns high on that same edge.
//   States: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
//   IDLE: s_axis_tready=1, txd=1.
//     - A beat is accepted on an edge where tvalid && tready.
//     - On that edge: capture tdata and the bit period P = max(prescale,1)*8 into a
//       19-bit register; load the bit counter with P-1; txd<=0; busy<=1; tready<=0;
//       state<=START.
//   Each bit holds txd for exactly P cycles. The counter decrements each cycle; at 0 the
//   next bit is driven and the counter reloads with P-1.
//   DATA: shift out the captured word LSB first, DATA_WIDTH bits.
//   PARITY: odd puts txd = ~^data; even puts txd = ^data.
//   STOP: txd=1 for STOP_BITS*P cycles. The edge that ends the last stop bit sets
//     busy<=0, tready<=1, state<=IDLE.
//   Back-to-back beats: the minimum start-to-start spacing is (1+DATA_WIDTH+(PARITY!=0)
//     +STOP_BITS)*P + 1 cycles. The +1 is the single tready-high cycle; txd stays high there.
//   prescale is sampled only at accept. Changes mid-frame do not affect the current frame.
//     prescale=0 is treated as 1.
//   tdata is sampled only at accept. Changes to tdata/tvalid while tready=0 are ignored.
//   tready never depends combinationally on tvalid.
//   No beat is ever dropped or duplicated. Every accepted beat produces exactly one
//     complete frame unless rst intervenes.
// TESTING
//   1. rst held 3 cycles, then released -> txd=1, busy=0 throughout reset;
//      tready=1 on the first edge after release.
//   2. prescale=1, send 0xA5 (PARITY=0, STOP_BITS=1) -> txd = 0,1,0,1,0,0,1,0,1,1,
//      each level held 8 clk; tready low for 80 clk and high on the next cycle.
//   3. tvalid held high with 3 words 0x00,0xFF,0x55 at prescale=2 -> three frames,
//      start edges 161 clk apart; each word sent exactly once and in order.
//   4. PARITY=2, send 0x07 -> parity bit = 1; PARITY=1, send 0x07 -> parity bit = 0.
//      STOP_BITS=2 gives a stop high for 2*P cycles.
//   5. prescale changed 1->4 mid-frame -> current frame keeps 8-cycle bits;
//      the next frame uses 32-cycle bits. prescale=0 -> 8-cycle bits.
//   6. rst asserted during DATA bit 3 -> txd=1, busy=0 on that edge; after release a new
//      beat transmits a clean full frame.

Source files
------------

// File: rtl/uart_tx_axis.sv
// uart_tx_axis -- UART transmitter fed by an AXI-Stream slave port.
//   One bit period = max(prescale,1)*8 clk cycles, latched when a beat is
//   accepted. Frame: start, DATA_WIDTH data bits LSB first, optional parity,
//   STOP_BITS stop bits.
// Ports:
//   clk            in   single clock, posedge
//   rst            in   synchronous active-high reset
//   s_axis_tdata   in   word to transmit
//   s_axis_tvalid  in   source has a word
//   s_axis_tready  out  registered; high only while idle
//   txd            out  serial line, idles high
//   busy           out  high while a frame is being shifted out
//   prescale       in   bit period in units of 8 clk cycles (0 treated as 1)
module uart_tx_axis #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state, w_state_nx;
  logic [18:0]           r_period, w_period_nx;
  logic [18:0]           r_cnt, w_cnt_nx;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nx;
  logic [3:0]            r_bit, w_bit_nx;
  logic                  r_par, w_par_nx;
  logic                  r_txd, w_txd_nx;
  logic                  r_busy, w_busy_nx;
  logic                  r_tready, w_tready_nx;

  logic [18:0]           w_accept_period;
  logic                  w_accept;
  logic                  w_cnt_zero;

  assign w_accept_period = (prescale == 16'd0) ? 19'd8 : {prescale, 3'b000};
  // r_tready is only ever high in S_IDLE, so this is the accept condition.
  assign w_accept        = s_axis_tvalid && r_tready;
  assign w_cnt_zero      = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_period <= '0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_bit    <= '0;
      r_par    <= 1'b0;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
      r_tready <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_period <= w_period_nx;
      r_cnt    <= w_cnt_nx;
      r_shift  <= w_shift_nx;
      r_bit    <= w_bit_nx;
      r_par    <= w_par_nx;
      r_txd    <= w_txd_nx;
      r_busy   <= w_busy_nx;
      r_tready <= w_tready_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_period_nx = r_period;
    w_cnt_nx    = r_cnt;
    w_shift_nx  = r_shift;
    w_bit_nx    = r_bit;
    w_par_nx    = r_par;
    w_txd_nx    = r_txd;
    w_busy_nx   = r_busy;
    w_tready_nx = r_tready;

    if (r_state == S_IDLE) begin
      w_txd_nx    = 1'b1;
      w_tready_nx = 1'b1;
      if (w_accept) begin
        w_shift_nx  = s_axis_tdata;
        w_period_nx = w_accept_period;
        w_cnt_nx    = w_accept_period - 19'd1;
        // Parity bit is fixed at capture time from the whole word.
        w_par_nx    = (PARITY == 1) ? ~^s_axis_tdata : ^s_axis_tdata;
        w_txd_nx    = 1'b0;
        w_busy_nx   = 1'b1;
        w_tready_nx = 1'b0;
        w_state_nx  = S_START;
      end
    end else if (!w_cnt_zero) begin
      w_cnt_nx = r_cnt - 19'd1;
    end else begin
      w_cnt_nx = r_period - 19'd1;
      case (r_state)
        S_START: begin
          w_txd_nx   = r_shift[0];
          w_shift_nx = r_shift >> 1;
          w_bit_nx   = '0;
          w_state_nx = S_DATA;
        end
        S_DATA: begin
          if (r_bit == 4'(DATA_WIDTH - 1)) begin
            w_bit_nx = '0;
            if (PARITY != 0) begin
              w_txd_nx   = r_par;
              w_state_nx = S_PARITY;
            end else begin
              w_txd_nx   = 1'b1;
              w_state_nx = S_STOP;
            end
          end else begin
            w_txd_nx   = r_shift[0];
            w_shift_nx = r_shift >> 1;
            w_bit_nx   = r_bit + 4'd1;
          end
        end
        S_PARITY: begin
          w_txd_nx   = 1'b1;
          w_bit_nx   = '0;
          w_state_nx = S_STOP;
        end
        S_STOP: begin
          if (r_bit == 4'(STOP_BITS - 1)) begin
            w_busy_nx   = 1'b0;
            w_tready_nx = 1'b1;
            w_cnt_nx    = '0;
            w_state_nx  = S_IDLE;
          end else begin
            w_bit_nx = r_bit + 4'd1;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign s_axis_tready = r_tready;
  assign txd           = r_txd;
  assign busy          = r_busy;

endmodule

// File: tb/tb_uart_tx_axis.sv
// tb_uart_tx_axis -- self-checking bench for uart_tx_axis.
//   Three instances with different frame formats share clk/rst/tdata/prescale;
//   each has its own tvalid. Expected line levels come from a frame model
//   built from the frame format (start, data LSB first, parity, stops).
module tb_uart_tx_axis;

  logic       clk;
  logic       rst;
  logic [8:0] tdata;
  logic [15:0] prescale;
  logic       tvalid_v [3];
  logic       tready_v [3];
  logic       txd_v    [3];
  logic       busy_v   [3];
  int         cyc;
  int         nchk;
  int         npass;

  uart_tx_axis #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[7:0]), .s_axis_tvalid(tvalid_v[0]),
    .s_axis_tready(tready_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .prescale(prescale));

  uart_tx_axis #(.DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[7:0]), .s_axis_tvalid(tvalid_v[1]),
    .s_axis_tready(tready_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .prescale(prescale));

  uart_tx_axis #(.DATA_WIDTH(6), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[5:0]), .s_axis_tvalid(tvalid_v[2]),
    .s_axis_tready(tready_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .prescale(prescale));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dw(input int k);
    return (k == 2) ? 6 : 8;
  endfunction
  function automatic int par(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction
  function automatic int sb(input int k);
    return (k == 1) ? 2 : 1;
  endfunction
  function automatic int frame_len(input int k);
    return 1 + dw(k) + ((par(k) != 0) ? 1 : 0) + sb(k);
  endfunction

  // Level of frame bit i for (already masked) word w.
  function automatic logic exp_bit(input int k, input logic [8:0] w, input int i);
    int ones;
    if (i == 0) return 1'b0;
    if (i <= dw(k)) return w[i-1];
    if (par(k) != 0 && i == dw(k) + 1) begin
      ones = $countones(w);
      if (par(k) == 1) return (ones % 2 == 0);
      return (ones % 2 == 1);
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Entered and left at a sample point (#1 after posedge).
  task automatic check_frame(input int k, input logic [8:0] word, input int pre,
                             input bit hold, output int acc_cyc);
    int waited;
    int p;
    logic [8:0] w;
    acc_cyc = 0;
    tdata = word;
    prescale = 16'(pre);
    tvalid_v[k] = 1'b1;
    waited = 0;
    while (!tready_v[k] && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!tready_v[k]) begin
      nchk++;
      $error("FAIL accept_timeout d%0d observed=tready_low expected=tready_high", k);
      tvalid_v[k] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!hold) tvalid_v[k] = 1'b0;
    p = ((pre == 0) ? 1 : pre) * 8;
    w = word & ((9'h1 << dw(k)) - 9'h1);
    for (int i = 0; i < frame_len(k); i++) begin
      for (int c = 0; c < p; c++) begin
        chk($sformatf("d%0d w%0h bit%0d c%0d txd", k, w, i, c), 32'(txd_v[k]), 32'(exp_bit(k, w, i)));
        chk($sformatf("d%0d busy", k), 32'(busy_v[k]), 32'd1);
        chk($sformatf("d%0d tready_low", k), 32'(tready_v[k]), 32'd0);
        // Inputs wiggle mid-frame; none of it may affect the current frame.
        tdata = 9'($urandom);
        prescale = 16'($urandom_range(0, 8));
        @(posedge clk); #1;
      end
    end
    chk($sformatf("d%0d end txd", k), 32'(txd_v[k]), 32'd1);
    chk($sformatf("d%0d end busy", k), 32'(busy_v[k]), 32'd0);
    chk($sformatf("d%0d end tready", k), 32'(tready_v[k]), 32'd1);
  endtask

  initial begin
    int a0, a1, a2;
    clk = 1'b0;
    rst = 1'b1;
    cyc = 0;
    nchk = 0;
    npass = 0;
    tdata = '0;
    prescale = 16'd1;
    for (int k = 0; k < 3; k++) tvalid_v[k] = 1'b0;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rst d%0d txd", k), 32'(txd_v[k]), 32'd1);
        chk($sformatf("rst d%0d busy", k), 32'(busy_v[k]), 32'd0);
        chk($sformatf("rst d%0d tready", k), 32'(tready_v[k]), 32'd0);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("release d%0d tready", k), 32'(tready_v[k]), 32'd1);

    // 0xA5 at prescale 1: 0,1,0,1,0,0,1,0,1,1 with 8-cycle bits.
    check_frame(0, 9'h0A5, 1, 1'b0, a0);

    // tvalid held across three words at prescale 2.
    check_frame(0, 9'h000, 2, 1'b1, a0);
    check_frame(0, 9'h0FF, 2, 1'b1, a1);
    check_frame(0, 9'h055, 2, 1'b0, a2);
    chk("b2b spacing 1", 32'(a1 - a0), 32'd161);
    chk("b2b spacing 2", 32'(a2 - a1), 32'd161);

    // Parity: even over 0x07 -> 1 (with two stop bits), odd -> 0.
    check_frame(1, 9'h007, 1, 1'b0, a0);
    check_frame(2, 9'h007, 1, 1'b0, a0);

    // prescale 1 frame (prescale wiggled mid-frame), then 4, then 0.
    check_frame(0, 9'h03C, 1, 1'b0, a0);
    check_frame(0, 9'h0C3, 4, 1'b0, a0);
    check_frame(0, 9'h05A, 0, 1'b0, a0);

    // Reset during data bit 3 of 0x37 (bit 3 is 0, so txd is low there).
    tdata = 9'h037;
    prescale = 16'd1;
    tvalid_v[0] = 1'b1;
    @(posedge clk); #1;
    tvalid_v[0] = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
    end
    chk("pre-rst data bit3", 32'(txd_v[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst txd", 32'(txd_v[0]), 32'd1);
    chk("midrst busy", 32'(busy_v[0]), 32'd0);
    chk("midrst tready", 32'(tready_v[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst release tready", 32'(tready_v[0]), 32'd1);
    check_frame(0, 9'h096, 1, 1'b0, a0);

    // Random words, formats and prescales.
    for (int n = 0; n < 12; n++)
      check_frame(int'($urandom_range(0, 2)), 9'($urandom), int'($urandom_range(0, 3)), 1'b0, a0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
